// File: rtl/motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// motor_pwm_driver
//   H-bridge output stage for two motor drivers (A, B). A shared prescaler and
//   three-digit BCD PWM counter (000..999) define the PWM period. Direction and
//   duty commands are sampled only on period boundaries, so pulses never glitch.
//   A direct forward<->reverse swap is routed through DEAD_PERIODS full periods
//   of coast (all pins low) before the new direction is applied.
//
// Ports
//   clk, rst_n                 system clock, asynchronous active-low reset
//   directie_driverA/B [1:0]   requested direction: 10 fwd, 01 rev, 00/11 stop
//   factor_dc_driverA/B [11:0] duty factor, 3-digit BCD 000..999
//   in1_a, in2_a, en_a         driver A direction pins and PWM enable
//   in1_b, in2_b, en_b         driver B direction pins and PWM enable
//   period_start               1-clk pulse in the cycle after a period boundary
//   bcd_err                    1-clk pulse (with period_start) when a sampled
//                              duty factor contains a digit above 9
// All outputs are registered.
// -----------------------------------------------------------------------------
module motor_pwm_driver #(
  parameter int PRESCALE     = 50,
  parameter int DEAD_PERIODS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  directie_driverA,
  input  logic [1:0]  directie_driverB,
  input  logic [11:0] factor_dc_driverA,
  input  logic [11:0] factor_dc_driverB,
  output logic        in1_a,
  output logic        in2_a,
  output logic        en_a,
  output logic        in1_b,
  output logic        in2_b,
  output logic        en_b,
  output logic        period_start,
  output logic        bcd_err
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [3:0]    DEAD_INIT = 4'(DEAD_PERIODS);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } ch_state_e;

  // True when every nibble is a legal decimal digit.
  function automatic logic bcd_ok(input logic [11:0] v);
    return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // BCD increment with decimal carry; 999 wraps to 000.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
        end
      end
    end
    return r;
  endfunction

  // a < b on BCD values, most significant digit decides first.
  function automatic logic bcd_lt(input logic [11:0] a, input logic [11:0] b);
    logic r;
    if (a[11:8] != b[11:8]) begin
      r = (a[11:8] < b[11:8]);
    end else if (a[7:4] != b[7:4]) begin
      r = (a[7:4] < b[7:4]);
    end else begin
      r = (a[3:0] < b[3:0]);
    end
    return r;
  endfunction

  // 11 carries no meaning and is handled as stop.
  function automatic logic [1:0] norm_dir(input logic [1:0] d);
    return (d == 2'b11) ? 2'b00 : d;
  endfunction

  function automatic logic is_motion(input logic [1:0] d);
    return (d == 2'b10) || (d == 2'b01);
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   cnt_q, cnt_d;
  logic          step_s, boundary_s;
  logic          period_start_q, period_start_d;
  logic          bcd_err_q, bcd_err_d;

  logic [1:0]    req_s   [2];
  logic [11:0]   fac_s   [2];
  ch_state_e     state_q [2];
  ch_state_e     state_d [2];
  logic [1:0]    dir_q   [2];
  logic [1:0]    dir_d   [2];
  logic [3:0]    dcnt_q  [2];
  logic [3:0]    dcnt_d  [2];
  logic [11:0]   duty_q  [2];
  logic [11:0]   duty_d  [2];
  logic          in1_q   [2];
  logic          in1_d   [2];
  logic          in2_q   [2];
  logic          in2_d   [2];
  logic          en_q    [2];
  logic          en_d    [2];

  assign req_s[0] = norm_dir(directie_driverA);
  assign req_s[1] = norm_dir(directie_driverB);
  assign fac_s[0] = factor_dc_driverA;
  assign fac_s[1] = factor_dc_driverB;

  // Prescaler and shared BCD PWM counter; boundary is the 999->000 step.
  always_comb begin
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    step_s     = (presc_q == PRESC_MAX);
    boundary_s = step_s && (cnt_q == 12'h999);
    if (step_s) begin
      presc_d = '0;
      cnt_d   = bcd_inc(cnt_q);
    end else begin
      presc_d = presc_q + PW'(1);
    end
    period_start_d = boundary_s;
    bcd_err_d      = boundary_s && (!bcd_ok(factor_dc_driverA) || !bcd_ok(factor_dc_driverB));
  end

  // Per-channel RUN/DEAD FSM, duty latch and registered pin values.
  // Pins and enable are derived from the next-state values so they line up
  // with the counter value they will be presented against.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      dir_d[ch]   = dir_q[ch];
      dcnt_d[ch]  = dcnt_q[ch];
      duty_d[ch]  = duty_q[ch];
      if (boundary_s) begin
        if (bcd_ok(fac_s[ch])) begin
          duty_d[ch] = fac_s[ch];
        end else begin
          duty_d[ch] = 12'h000;
        end
        case (state_q[ch])
          ST_RUN: begin
            if (req_s[ch] == dir_q[ch]) begin
              state_d[ch] = ST_RUN;
            end else if (is_motion(req_s[ch]) && is_motion(dir_q[ch])) begin
              // Direct reversal: coast first.
              state_d[ch] = ST_DEAD;
              dcnt_d[ch]  = DEAD_INIT;
              dir_d[ch]   = 2'b00;
            end else begin
              dir_d[ch] = req_s[ch];
            end
          end
          ST_DEAD: begin
            if (!is_motion(req_s[ch])) begin
              state_d[ch] = ST_RUN;
              dir_d[ch]   = 2'b00;
              dcnt_d[ch]  = 4'd0;
            end else if (dcnt_q[ch] <= 4'd1) begin
              state_d[ch] = ST_RUN;
              dir_d[ch]   = req_s[ch];
              dcnt_d[ch]  = 4'd0;
            end else begin
              dcnt_d[ch] = dcnt_q[ch] - 4'd1;
            end
          end
          default: begin
            state_d[ch] = ST_RUN;
            dir_d[ch]   = 2'b00;
            dcnt_d[ch]  = 4'd0;
          end
        endcase
      end else begin
        duty_d[ch] = duty_q[ch];
      end
      in1_d[ch] = (state_d[ch] == ST_RUN) && (dir_d[ch] == 2'b10);
      in2_d[ch] = (state_d[ch] == ST_RUN) && (dir_d[ch] == 2'b01);
      en_d[ch]  = (state_d[ch] == ST_RUN) && is_motion(dir_d[ch]) && bcd_lt(cnt_d, duty_d[ch]);
    end
  end

  // Shared timing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= 12'h000;
      period_start_q <= 1'b0;
      bcd_err_q      <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
      bcd_err_q      <= bcd_err_d;
    end
  end

  // Per-channel state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= ST_RUN;
        dir_q[ch]   <= 2'b00;
        dcnt_q[ch]  <= 4'd0;
        duty_q[ch]  <= 12'h000;
        in1_q[ch]   <= 1'b0;
        in2_q[ch]   <= 1'b0;
        en_q[ch]    <= 1'b0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        dir_q[ch]   <= dir_d[ch];
        dcnt_q[ch]  <= dcnt_d[ch];
        duty_q[ch]  <= duty_d[ch];
        in1_q[ch]   <= in1_d[ch];
        in2_q[ch]   <= in2_d[ch];
        en_q[ch]    <= en_d[ch];
      end
    end
  end

  assign in1_a        = in1_q[0];
  assign in2_a        = in2_q[0];
  assign en_a         = en_q[0];
  assign in1_b        = in1_q[1];
  assign in2_b        = in2_q[1];
  assign en_b         = en_q[1];
  assign period_start = period_start_q;
  assign bcd_err      = bcd_err_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_motor_pwm_driver
//   Scoreboard bench. On every rising edge a behavioural model (integer tick
//   count, decimal duty values, remaining-dead-periods count) computes the
//   expected output vector and pushes it to a queue; a monitor on the falling
//   edge pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_motor_pwm_driver;

  localparam int PRESCALE = 1;
  localparam int DEAD     = 2;
  localparam int PER      = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  dir_a = 2'b00, dir_b = 2'b00;
  logic [11:0] fac_a = 12'h000, fac_b = 12'h000;
  logic        in1_a, in2_a, en_a, in1_b, in2_b, en_b, period_start, bcd_err;

  always #5 clk = ~clk;

  motor_pwm_driver #(.PRESCALE(PRESCALE), .DEAD_PERIODS(DEAD)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .directie_driverA (dir_a),
    .directie_driverB (dir_b),
    .factor_dc_driverA(fac_a),
    .factor_dc_driverB(fac_b),
    .in1_a            (in1_a),
    .in2_a            (in2_a),
    .en_a             (en_a),
    .in1_b            (in1_b),
    .in2_b            (in2_b),
    .en_b             (en_b),
    .period_start     (period_start),
    .bcd_err          (bcd_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];
  bit rnd_on = 1'b0;

  // Behavioural reference state
  int         m_tick;
  int         m_duty [2];
  logic [1:0] m_dir  [2];
  int         m_dead [2];
  bit         m_ps, m_err;

  function automatic int bcd_val(input logic [11:0] v);
    int d2, d1, d0;
    d2 = int'(v[11:8]); d1 = int'(v[7:4]); d0 = int'(v[3:0]);
    if (d2 > 9 || d1 > 9 || d0 > 9) return -1;
    return d2 * 100 + d1 * 10 + d0;
  endfunction

  function automatic logic [1:0] nd(input logic [1:0] d);
    return (d == 2'b11) ? 2'b00 : d;
  endfunction

  function automatic logic [7:0] model_out();
    int pos;
    logic [2:0] ch_bits [2];
    pos = (m_tick % (PER * PRESCALE)) / PRESCALE;
    for (int ch = 0; ch < 2; ch++) begin
      ch_bits[ch][2] = (m_dir[ch] == 2'b10);
      ch_bits[ch][1] = (m_dir[ch] == 2'b01);
      ch_bits[ch][0] = (m_dead[ch] == 0) && (m_dir[ch] != 2'b00) && (pos < m_duty[ch]);
    end
    return {ch_bits[0], ch_bits[1], m_ps, m_err};
  endfunction

  task automatic model_reset();
    m_tick = 0; m_ps = 1'b0; m_err = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      m_duty[ch] = 0; m_dir[ch] = 2'b00; m_dead[ch] = 0;
    end
  endtask

  task automatic model_step();
    logic [1:0]  r;
    logic [11:0] f;
    int v;
    bit bnd, bad;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_tick++;
      bnd = (m_tick % (PER * PRESCALE)) == 0;
      bad = 1'b0;
      if (bnd) begin
        for (int ch = 0; ch < 2; ch++) begin
          r = nd(ch == 0 ? dir_a : dir_b);
          f = (ch == 0) ? fac_a : fac_b;
          v = bcd_val(f);
          if (v < 0) bad = 1'b1;
          m_duty[ch] = (v < 0) ? 0 : v;
          if (m_dead[ch] > 0) begin
            if (r == 2'b00) begin
              m_dead[ch] = 0; m_dir[ch] = 2'b00;
            end else begin
              m_dead[ch]--;
              if (m_dead[ch] == 0) m_dir[ch] = r;
            end
          end else if (r != m_dir[ch]) begin
            if (r != 2'b00 && m_dir[ch] != 2'b00) begin
              m_dead[ch] = DEAD; m_dir[ch] = 2'b00;
            end else begin
              m_dir[ch] = r;
            end
          end
        end
      end
      m_ps  = bnd;
      m_err = bnd && bad;
    end
  endtask

  // Monitor: compare DUT outputs with the oldest expectation.
  always @(negedge clk) begin
    logic [7:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {in1_a, in2_a, en_a, in1_b, in2_b, en_b, period_start, bcd_err};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t tick=%0d got=%b want=%b (in1a in2a ena in1b in2b enb ps err)",
                 $time, m_tick, a, e);
      end
    end
  end

  function automatic logic [11:0] rand_duty();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 12'h000;
    if (k == 1) return 12'h999;
    if (k == 2) return 12'($urandom_range(0, 4095));
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic random_change();
    case ($urandom_range(0, 3))
      0: dir_a = 2'($urandom_range(0, 3));
      1: dir_b = 2'($urandom_range(0, 3));
      2: fac_a = rand_duty();
      default: fac_b = rand_duty();
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (rnd_on && $urandom_range(0, 299) == 0) random_change();
    end
  endtask

  initial begin
    logic [7:0] a;
    bit found;
    model_reset();
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;

    // Basic PWM: A forward 999, B forward 000
    dir_a = 2'b10; fac_a = 12'h999; dir_b = 2'b10; fac_b = 12'h000;
    run(3 * PER + 5);

    // Duty 250, then 750 mid-period
    fac_a = 12'h250; fac_b = 12'h600;
    run(1500);
    fac_a = 12'h750;
    run(1600);

    // Direct swap A 10 -> 01: dead time, B unaffected
    dir_a = 2'b01;
    run(4 * PER);

    // Stop, then reverse without dead time
    dir_a = 2'b00;
    run(2 * PER);
    dir_a = 2'b01;
    run(2 * PER);

    // Illegal BCD duty and code 11
    fac_a = 12'h9A0;
    run(2 * PER);
    fac_a = 12'h400; dir_a = 2'b11;
    run(2 * PER);

    // Swap, revert during dead; then swap and stop during dead
    dir_a = 2'b10; run(PER + 10);
    dir_a = 2'b01; run(PER);
    dir_a = 2'b10; run(3 * PER);
    dir_a = 2'b01; run(PER + 10);
    dir_a = 2'b00; run(2 * PER);

    // Async reset mid-period during DEAD with B active
    dir_a = 2'b10; fac_a = 12'h500; fac_b = 12'h999; dir_b = 2'b10;
    run(2 * PER);
    dir_a = 2'b01;
    found = 1'b0;
    for (int i = 0; i < 3 * PER && !found; i++) begin
      cycle();
      if (m_dead[0] > 0) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL dead_entry got=no_dead want=dead");
    end
    run(300);
    #2 rst_n = 1'b0;
    #1;
    a = {in1_a, in2_a, en_a, in1_b, in2_b, en_b, period_start, bcd_err};
    n_tests++;
    if (a !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset got=%b want=00000000", a);
    end
    run(3);
    rst_n = 1'b1;
    run(PER + 20);

    // Randomised traffic
    rnd_on = 1'b1;
    run(15 * PER);
    rnd_on = 1'b0;

    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
Output stage directly downstream of the motion-logic block. Per motor driver (A, B) it converts the 2-bit direction code and the 12-bit BCD duty factor (000..999) into H-bridge direction pins and a PWM enable. It runs a shared BCD PWM counter and latches new commands only at period boundaries, so pulses never glitch. It inserts coast dead-time on direct forward/reverse swaps.

Parameters:
PRESCALE, 50, clk cycles per PWM counter step (>=1); PWM period = 1000*PRESCALE clk cycles
DEAD_PERIODS, 2, full PWM periods of coast inserted on a direct 10<->01 swap (>=1, max 15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
directie_driverA  in  2  requested direction code, driver A
directie_driverB  in  2  requested direction code, driver B
factor_dc_driverA  in  12  duty factor, driver A, 3-digit BCD
factor_dc_driverB  in  12  duty factor, driver B, 3-digit BCD
in1_a, in2_a  out  1 each  H-bridge direction pins, driver A
en_a  out  1  PWM enable, driver A
in1_b, in2_b  out  1 each  H-bridge direction pins, driver B
en_b  out  1  PWM enable, driver B
period_start  out  1  1-clk pulse on each PWM period boundary
bcd_err  out  1  1-clk pulse when a sampled duty has a digit >9

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n=0 clears everything immediately. All outputs 0, counters 000, applied dir 00, latched duty 000, both FSMs RUN.
- Prescaler: counts 0..PRESCALE-1. step = (presc==PRESCALE-1).
- PWM counter: 3 BCD digits. Increments on step with decimal carry. 999 -> 000 on step.
- Boundary: the step at which the counter goes 999->000.
  - period_start=1 for the clk cycle after that edge.
  - All per-channel sampling happens on the boundary edge.
  - First boundary after reset is 1000*PRESCALE clk cycles after reset release.
- Duty latch: at boundary, duty_q <= factor. If any nibble >9, duty_q <= 000 and bcd_err pulses with period_start; either channel can trigger it.
- Enable: en = RUN and (cnt < duty_q), registered, compared digit-wise with MSD priority. Duty 000 gives en always 0. Duty 999 gives en high 999 of 1000 steps. Duty 500 gives exactly 500 steps high per period.
- Direction codes: 10 = forward (in1=1, in2=0); 01 = reverse (in1=0, in2=1); 00 = stop (in1=0, in2=0, en forced 0). 11 is treated as 00.
- Per-channel FSM RUN/DEAD, with applied dir_q and dead counter dcnt:
  - RUN at boundary, req==dir_q: no change.
  - RUN at boundary, req and dir_q are the two opposite motion codes: go to DEAD, dcnt <= DEAD_PERIODS, dir_q <= 00.
  - RUN at boundary, any other change (involves 00/11): dir_q <= req immediately.
  - DEAD: in1=in2=en=0 regardless of duty. Each boundary decrements dcnt. When dcnt reaches 0, dir_q <= the req sampled at that boundary and go to RUN.
  - DEAD, req becomes 00/11 at a boundary: exit early to RUN with dir_q=00.
  - DEAD, req reverts to the old direction: dead time still completes.
- Latency: a command change is reflected on the pins by the first clk after the next boundary. The worst case is 1000*PRESCALE+1 cycles; a swap adds DEAD_PERIODS periods.
- Input changes between boundaries are ignored; no synchronisers are needed because inputs come from the same clock domain.
- Channels A and B are fully independent apart from the shared counter and bcd_err.

Test Plan:
- PRESCALE=1, reset, A=10/999, B=10/000 -> first boundary at cycle 1000. Then in1_a=1, in2_a=0; en_a high 999 of every 1000 cycles; en_b constantly 0; period_start every 1000 cycles.
- A=10, duty 12'h250 -> en_a high exactly 250 consecutive cycles from period_start. Change duty to 12'h750 mid-period -> no change until the next boundary, then 750 high.
- DEAD_PERIODS=2, A running 10, request 01 -> boundary 1: pins 00 and en_a=0 for 2 full periods. Then in1_a=0, in2_a=1 and PWM resumes. B is unaffected throughout.
- A running 10, request 00 -> pins 00 and en_a=0 at the next boundary, with no dead time. Then request 01 -> reverse at the following boundary, with no dead time.
- Duty 12'h9A0 -> bcd_err pulse coincides with period_start, and en_a stays 0 for that period. Request 11 -> pins 00.
- Assert rst_n low mid-period during DEAD -> all outputs 0 in the same cycle, without waiting for clk. After release, the first boundary is at 1000 cycles and the FSM is in RUN with dir 00.
